// File: rtl/fft_out_collector.sv
// FFT output collector: assembles real/imag lane beats into ping-pong frame banks.
// Optional macro FFT_OUT_BITREV_EN stores word k at slot bitrev(k) (natural frequency order).
module fft_out_collector #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BEATS  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]        in_data,
    input  logic                                   in_part,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [2*NUM_BEATS*NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   seq_err
);

    localparam int unsigned TW = NUM_BEATS * NUM_LANES;
    localparam int unsigned OW = 2 * TW * DATA_WIDTH;
    localparam int unsigned CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

`ifdef FFT_OUT_BITREV_EN
    localparam int unsigned LOGTW = $clog2(TW);

    if ((TW & (TW - 1)) != 0) begin : g_tw_not_pow2
        $error("fft_out_collector: TW must be a power of two when bit reversal is enabled");
    end
`endif

    typedef enum logic {
        PH_RE = 1'b0,
        PH_IM = 1'b1
    } phase_e;

    logic [1:0][OW-1:0] bank_q, bank_d;
    logic [1:0]         bank_full_q, bank_full_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    phase_e             phase_q, phase_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               seq_err_q, seq_err_d;

    logic accept;
    logic part_ok;
    logic drain;

    // Bit offset of one part of a lane word inside a bank, after slot mapping.
    function automatic int unsigned part_lsb(input logic [CW-1:0] cnt,
                                             input int unsigned lane,
                                             input logic im);
        int unsigned k;
        int unsigned slot;
        k = int'(cnt) * NUM_LANES + lane;
`ifdef FFT_OUT_BITREV_EN
        slot = 0;
        for (int unsigned b = 0; b < LOGTW; b++) begin
            slot = slot | (((k >> b) & 1) << (LOGTW - 1 - b));
        end
`else
        slot = k;
`endif
        return (2 * slot + (im ? 1 : 0)) * DATA_WIDTH;
    endfunction

    assign in_ready  = !bank_full_q[wr_bank_q];
    assign out_valid = bank_full_q[rd_bank_q];
    assign out_data  = bank_q[rd_bank_q];
    assign seq_err   = seq_err_q;

    assign accept  = in_valid && in_ready && !flush;
    assign part_ok = (in_part == (phase_q == PH_IM));
    assign drain   = out_valid && out_ready;

    always_comb begin
        bank_d      = bank_q;
        bank_full_d = bank_full_q;
        beat_cnt_d  = beat_cnt_q;
        phase_d     = phase_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        seq_err_d   = seq_err_q;

        if (flush) begin
            bank_full_d = '0;
            beat_cnt_d  = '0;
            phase_d     = PH_RE;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            seq_err_d   = 1'b0;
        end else begin
            if (accept && !part_ok) begin
                seq_err_d = 1'b1;
            end
            if (accept && part_ok) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    bank_d[wr_bank_q][part_lsb(beat_cnt_q, l, phase_q == PH_IM) +: DATA_WIDTH] =
                        in_data[l*DATA_WIDTH +: DATA_WIDTH];
                end
                if (phase_q == PH_RE) begin
                    phase_d = PH_IM;
                end else begin
                    phase_d = PH_RE;
                    if (beat_cnt_q == CW'(NUM_BEATS - 1)) begin
                        bank_full_d[wr_bank_q] = 1'b1;
                        wr_bank_d              = !wr_bank_q;
                        beat_cnt_d             = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            // A completing write and a drain never hit the same bank: a full rd bank blocks input.
            if (drain) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q      <= '0;
            bank_full_q <= '0;
            beat_cnt_q  <= '0;
            phase_q     <= PH_RE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            bank_full_q <= bank_full_d;
            beat_cnt_q  <= beat_cnt_d;
            phase_q     <= phase_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            seq_err_q   <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_fft_out_collector.sv
// Scoreboard bench for fft_out_collector (NUM_LANES=2, DATA_WIDTH=8, NUM_BEATS=2).
module tb_fft_out_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] in_data;
    logic        in_part;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        seq_err;

`ifdef FFT_OUT_BITREV_EN
    localparam logic [63:0] FRAME_A = 64'h8866_4422_7755_3311;
    localparam logic [63:0] FRAME_B = 64'h0806_0402_0705_0301;
    localparam logic [63:0] FRAME_C = 64'hD2C2_B2A2_D1C1_B1A1;
`else
    localparam logic [63:0] FRAME_A = 64'h8866_7755_4422_3311;
    localparam logic [63:0] FRAME_B = 64'h0806_0705_0402_0301;
    localparam logic [63:0] FRAME_C = 64'hD2C2_D1C1_B2A2_B1A1;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    fft_out_collector #(
        .NUM_LANES (2),
        .DATA_WIDTH(8),
        .NUM_BEATS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  (in_data),
        .in_part  (in_part),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    // Monitor: every frame handed off must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL frame_unexpected: got %h, no frame expected", out_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL frame_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic part, input logic [15:0] d);
        int n = 0;
        in_part  = part;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: in_ready stuck at 0, required 1");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] r0, input logic [15:0] i0,
                         input logic [15:0] r1, input logic [15:0] i1);
        beat(1'b0, r0);
        beat(1'b1, i0);
        beat(1'b0, r1);
        beat(1'b1, i1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: out_valid stuck at 0, required 1");
        end else begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_data = '0; in_part = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_seq_err",   64'(seq_err),   64'd0);
        check("rst_out_data",  out_data,       64'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Basic frame with latency check
        exp_q.push_back(FRAME_A);
        beat(1'b0, 16'h2211);
        beat(1'b1, 16'h4433);
        beat(1'b0, 16'h6655);
        check("basic_valid_early", 64'(out_valid), 64'd0);
        beat(1'b1, 16'h8877);
        check("basic_valid_lat1", 64'(out_valid), 64'd1);
        check("basic_in_ready",   64'(in_ready),  64'd1);
        drain();
        check("basic_drained", 64'(out_valid), 64'd0);

        // Ping-pong backpressure
        exp_q.push_back(FRAME_A);
        frame(16'h2211, 16'h4433, 16'h6655, 16'h8877);
        exp_q.push_back(FRAME_B);
        frame(16'h0201, 16'h0403, 16'h0605, 16'h0807);
        check("pp_in_ready_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_part = 1'b0; in_data = 16'h5A5A;
        repeat (3) @(posedge clk);
        #1;
        check("pp_stall_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        drain();
        check("pp_in_ready_back", 64'(in_ready),  64'd1);
        check("pp_next_valid",    64'(out_valid), 64'd1);
        exp_q.push_back(FRAME_C);
        beat(1'b0, 16'hA2A1);
        beat(1'b1, 16'hB2B1);
        beat(1'b0, 16'hC2C1);
        out_ready = 1'b1;
        beat(1'b1, 16'hD2D1);
        check("simul_valid",    64'(out_valid), 64'd1);
        check("simul_in_ready", 64'(in_ready),  64'd1);
        drain();

        // Sequence error
        beat(1'b0, 16'h2211);
        beat(1'b0, 16'h9999);
        check("seq_err_set", 64'(seq_err), 64'd1);
        exp_q.push_back(FRAME_A);
        beat(1'b1, 16'h4433);
        beat(1'b0, 16'h6655);
        beat(1'b1, 16'h8877);
        check("seq_err_sticky", 64'(seq_err),   64'd1);
        check("seq_frame_valid", 64'(out_valid), 64'd1);
        drain();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("seq_err_flushed", 64'(seq_err), 64'd0);

        // Flush with a held frame and a partial frame, beat in the flush cycle
        frame(16'h0201, 16'h0403, 16'h0605, 16'h0807);
        beat(1'b1, 16'h7777);
        beat(1'b0, 16'h0201);
        beat(1'b1, 16'h0403);
        beat(1'b0, 16'h0605);
        flush = 1'b1; in_valid = 1'b1; in_part = 1'b1; in_data = 16'hEEEE;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_seq_err",   64'(seq_err),   64'd0);
        exp_q.push_back(FRAME_A);
        frame(16'h2211, 16'h4433, 16'h6655, 16'h8877);
        check("flush_frame_valid", 64'(out_valid), 64'd1);
        drain();

        // Async reset with a held frame, seq_err set and a partial frame
        frame(16'h0201, 16'h0403, 16'h0605, 16'h0807);
        beat(1'b1, 16'h1111);
        beat(1'b0, 16'h0201);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_seq_err",   64'(seq_err),   64'd0);
        check("arst_out_data",  out_data,       64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(FRAME_A);
        frame(16'h2211, 16'h4433, 16'h6655, 16'h8877);
        check("arst_frame_valid", 64'(out_valid), 64'd1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_out_collector.md
Name: fft_out_collector

Overview:
- Parametrised output collector for the FFT datapath. Each input beat carries NUM_LANES real or imaginary parts from the butterfly stage.
- Beats are assembled into a full frame of NUM_BEATS*NUM_LANES complex words.
- The frame is presented on a wide packed bus with valid/ready handshake.
- Two ping-pong banks let collection of frame n+1 overlap draining of frame n.

Parameters:
- NUM_LANES, 2, complex words delivered per beat (lanes)
- DATA_WIDTH, 8, bits per real or imaginary part
- NUM_BEATS, 4, beat pairs (real+imag) per frame; total words TW = NUM_BEATS*NUM_LANES

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort: discard partial/held frames
- in_data  in  NUM_LANES*DATA_WIDTH  lane l at [(l+1)*DW-1 : l*DW]
- in_part  in  1  0 = real parts, 1 = imaginary parts
- in_valid  in  1  input beat valid
- in_ready  out  1  collector can accept a beat
- out_data  out  2*TW*DATA_WIDTH  word k real at [(2k+1)*DW-1 : 2k*DW], imag at [(2k+2)*DW-1 : (2k+1)*DW]
- out_valid  out  1  complete frame available
- out_ready  in  1  consumer accepts frame
- seq_err  out  1  sticky: a beat arrived with the wrong in_part

Behaviour:
- Reset (rst low, async): both banks = 0, beat_cnt = 0, phase = 0 (expect real), wr_bank = rd_bank = 0, bank_full = 2'b00.
- Output reset values: out_data = 0, out_valid = 0, in_ready = 1, seq_err = 0.
- Accept condition: in_valid && in_ready, where in_ready = !bank_full[wr_bank].
- Accepted beat with in_part == phase:
  - Lane l is written to word k = beat_cnt*NUM_LANES + l of bank wr_bank.
  - Real part goes to the real slot when phase = 0, imaginary part to the imag slot when phase = 1.
  - Then phase toggles. When phase was 1, beat_cnt increments.
- Accepted beat with in_part != phase:
  - Data is discarded; phase and beat_cnt are unchanged.
  - seq_err is set and held until rst or flush.
- Frame complete: accepted imag beat with beat_cnt == NUM_BEATS-1.
  - Same edge: bank_full[wr_bank] <= 1, wr_bank toggles, beat_cnt <= 0, phase <= 0.
  - out_valid rises the next cycle if that bank is rd_bank (latency 1 cycle from final accept).
- Output side:
  - out_valid = bank_full[rd_bank]; out_data = bank[rd_bank], combinational mux.
  - Contents are stable while out_valid && !out_ready.
  - On out_valid && out_ready: bank_full[rd_bank] <= 0, rd_bank toggles.
- Simultaneous frame complete and drain: both updates apply in the same cycle (they target different banks).
- Both banks full: in_ready = 0 and input stalls. A drain makes in_ready 1 the next cycle.
- A beat arriving while in_ready = 0 is ignored, not buffered.
- flush (synchronous, priority over all other updates):
  - beat_cnt, phase, bank_full, wr_bank, rd_bank, seq_err are cleared.
  - Bank contents are retained but invisible (out_valid = 0).
  - An input beat in the same cycle is dropped.
- Reset mid-frame: partial frame lost; the restart behaves as from power-up.
- Counter width: clog2(NUM_BEATS), minimum 1 bit.

Optional Feature:
- Macro FFT_OUT_BITREV_EN.
- Defined:
  - Word index k is written to slot bitrev(k) over log2(TW) bits, so out_data is in natural frequency order for a DIT/DIF core producing bit-reversed output.
  - TW must be a power of two; a non-power-of-two TW is an elaboration error.
- Undefined: slot = k (arrival order); no constraint on TW.

Test Plan:
- Basic frame (NUM_LANES=2, DW=8, NUM_BEATS=2). Feed real 8'h11,8'h22 / imag 8'h33,8'h44 / real 8'h55,8'h66 / imag 8'h77,8'h88.
  - out_valid is 1 one cycle after the 4th accept.
  - out_data = 64'h8866_7755_4422_3311 (word0 r=11 i=33, word1 r=22 i=44, word2 r=55 i=77, word3 r=66 i=88).
- Ping-pong backpressure: out_ready = 0, send 3 frames.
  - Two frames are accepted; in_ready drops after frame 2 completes.
  - Pulse out_ready: frame 1 drains, frame 2 is presented next, and in_ready returns 1 the following cycle.
- Sequence error: two consecutive in_part = 0 beats.
  - The second is discarded and seq_err = 1.
  - A following imag beat completes the pair correctly; seq_err stays 1 until flush.
- Flush mid-frame after 3 beats, with in_valid high in the flush cycle.
  - in_ready = 1, out_valid = 0, seq_err = 0.
  - The next 4 beats form a clean frame equal to the basic-frame result.
- Async reset asserted mid-frame and while out_valid = 1: all outputs go to their reset values immediately, without a clock edge.
- FFT_OUT_BITREV_EN defined, same stimulus as the basic frame: slot order is 0,2,1,3, so out_data = 64'h8866_4422_7755_3311.
